sigmoid_pipe: RTL and testbench
===============================

Name: sigmoid_pipe

Overview:
- Pipelined, parametrised fixed-point activation unit for the neural datapath.
- Evaluates sigmoid or tanh on a signed two's-complement input.
- Uses a 29-entry breakpoint table over [-7, 7] with step 0.5, plus linear interpolation between breakpoints.
- Adds a valid/ready stream handshake, per-sample mode select, a sideband tag and full backpressure.

Parameters:
- DATA_W, 16: input and output width, signed two's complement.
- FRAC_W, 12: fractional bits of input and output; legal range 8..(DATA_W-4).
- TAG_W, 4: width of the sideband tag carried alongside each sample.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_x  in  DATA_W  signed input, Q(DATA_W-FRAC_W).FRAC_W.
- in_mode  in  1  0 = sigmoid, 1 = tanh.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_y  out  DATA_W  signed result, same Q format as in_x.
- out_tag  out  TAG_W  tag of the sample in out_y.

Behaviour:
- Reset: when rst_n is low at a clock edge, all stage valids clear; out_valid=0, out_y=0, out_tag=0. Reset mid-stream discards every in-flight sample with no output. in_ready=1 during and after reset.
- Handshake:
  - adv = out_ready | ~out_valid; in_ready = adv (combinational).
  - A sample transfers in when in_valid & in_ready; a result transfers out when out_valid & out_ready.
  - When adv=0 all stages hold; out_y and out_tag stay stable while out_valid=1 and out_ready=0.
  - Sustained throughput is 1 sample per clock. Latency is 3 clocks from accept to out_valid with no stall.
- Table: T[k] = round-half-up(2^FRAC_W * sigma(-7 + k/2)), k = 0..28, generated by a constant function at elaboration. T[0] is forced to 0 and T[28] to 1.0 (2^FRAC_W). Values at FRAC_W=12:
  - T[14]=0x0800, T[15]=0x09F6, T[16]=0x0BB2, T[13]=0x060A.
- Stage 1 (argument):
  - Sigmoid: z = x.
  - Tanh: z = 2x, computed at DATA_W+1 bits, no wrap.
  - If z <= -7.0, set the sat_lo flag. If z >= 7.0, set the sat_hi flag.
  - Otherwise k = floor((z + 7.0) / 0.5), 0..27, and f = the low FRAC_W-1 bits of (z + 7.0) (position within the half-unit segment).
  - Register k, f, mode, tag and the flags.
- Stage 2 (lookup):
  - Read a = T[k] and b = T[k+1].
  - d = b - a, which is always >= 0 because the table is monotonic.
  - Register a, d, f and the flags.
- Stage 3 (interpolate and post-process):
  - s = a + ((d * f) >> (FRAC_W-1)). The product is truncated, no rounding; the full product width is DATA_W+FRAC_W.
  - sat_lo forces s = 0; sat_hi forces s = 2^FRAC_W.
  - Sigmoid: y = s. Tanh: y = 2s - 2^FRAC_W.
  - Output range: sigmoid [0, 1.0], tanh [-1.0, 1.0]; no overflow is possible.
- Exact breakpoints: f = 0, so y = T[k] exactly.
- Input wrap: none. The most negative input value saturates low.
- Simultaneous events: in the same cycle, an output pop and an input push are both accepted with no bubble.

Test Plan:
- Reset, then sigmoid x=0x0000, out_ready=1 -> out_valid rises exactly 3 clocks after accept with y=0x0800. Sigmoid x=0x0800 (0.5) -> y=0x09F6. Sigmoid x=0xF800 (-0.5) -> y=0x060A.
- Interpolation, sigmoid x=0x0400 (0.25) -> y = 0x0800 + (502*1024>>11) = 0x08FB (2299).
- Saturation: sigmoid x=0x7000 -> 0x1000; x=0x7FFF -> 0x1000; x=0x9000 -> 0x0000; x=0x8000 -> 0x0000. Tanh x=0x4000 (4.0) -> 0x1000; tanh x=0xC000 -> 0xF000.
- Tanh: x=0 -> 0x0000. x=0x0400 (0.25) -> 2*0x09F6 - 0x1000 = 0x03EC. Mixed sigmoid/tanh back-to-back -> each out_tag matches its own result.
- Backpressure: stream 8 samples with tags 0..7, out_ready toggled pseudo-randomly -> no loss or duplication, in-order tags, out_y stable while stalled. in_ready=0 exactly when out_valid=1 and out_ready=0.
- Reset mid-stream: rst_n low 1 clock with 3 samples in flight -> those samples never appear, out_valid=0 next cycle, and the next accepted sample emerges after 3 clocks.

Source files
------------

// File: rtl/sigmoid_pipe.sv
// Three-stage pipelined sigmoid/tanh unit: breakpoint table over [-7, 7] in
// half-unit steps with linear interpolation and a stall-all valid/ready handshake.
module sigmoid_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 12,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_y,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned NPTS = 29;
  localparam int unsigned KW   = 5;
  localparam int unsigned ZW   = DATA_W + 2;
  localparam int unsigned FW   = FRAC_W - 1;
  localparam int unsigned UW   = FRAC_W + KW - 1;
  localparam int unsigned PW   = DATA_W + FRAC_W;

  localparam logic signed [ZW-1:0] SEVEN = ZW'(7 << FRAC_W);
  localparam logic [DATA_W-1:0]    ONE_Q = DATA_W'(1 << FRAC_W);
  localparam longint               EXP_ONE = longint'(1) << 30;

  // Table entry k = round-half-up(2^FRAC_W * sigma(-7 + k/2)) in 2^-30 integer arithmetic.
  function automatic logic [DATA_W-1:0] table_entry(input int k);
    longint term;
    longint p;
    longint e;
    longint num;
    longint den;
    longint v;
    int     m;
    if (k == 0) return '0;
    if (k == int'(NPTS) - 1) return ONE_Q;
    term = EXP_ONE;
    p    = EXP_ONE;
    for (int n = 1; n < 24; n++) begin
      term = -term / longint'(2 * n);
      p    = p + term;
    end
    m = (k >= 14) ? (k - 14) : (14 - k);
    e = EXP_ONE;
    for (int i = 0; i < m; i++) begin
      e = (e * p) >>> 30;
    end
    num = (k >= 14) ? EXP_ONE : e;
    den = EXP_ONE + e;
    v   = (num * (longint'(1) <<< (FRAC_W + 1)) + den) / (2 * den);
    return DATA_W'(v);
  endfunction

  logic [DATA_W-1:0] tbl [NPTS];

  for (genvar g = 0; g < int'(NPTS); g++) begin : g_tbl
    localparam logic [DATA_W-1:0] TV = table_entry(g);
    assign tbl[g] = TV;
  end

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage 1 argument: scale for tanh, detect saturation, split into segment and offset.
  logic signed [ZW-1:0] x_ext_c;
  logic signed [ZW-1:0] z_c;
  logic [UW-1:0]        u_c;
  logic                 sat_lo_c;
  logic                 sat_hi_c;

  always_comb begin
    x_ext_c  = ZW'(in_x);
    z_c      = in_mode ? (x_ext_c <<< 1) : x_ext_c;
    sat_lo_c = (z_c <= -SEVEN);
    sat_hi_c = (z_c >= SEVEN);
    u_c      = (sat_lo_c || sat_hi_c) ? '0 : UW'(z_c + SEVEN);
  end

  logic              v1;
  logic [KW-1:0]     k1;
  logic [FW-1:0]     f1;
  logic              mode1;
  logic [TAG_W-1:0]  tag1;
  logic              lo1;
  logic              hi1;

  logic              v2;
  logic [DATA_W-1:0] a2;
  logic [DATA_W-1:0] d2;
  logic [FW-1:0]     f2;
  logic              mode2;
  logic [TAG_W-1:0]  tag2;
  logic              lo2;
  logic              hi2;

  // Stage 3 interpolate, then map to sigmoid or tanh range.
  logic [DATA_W-1:0] s_c;
  logic [DATA_W-1:0] y_c;

  always_comb begin
    s_c = a2 + DATA_W'((PW'(d2) * PW'(f2)) >> FW);
    if (lo2) begin
      s_c = '0;
    end else if (hi2) begin
      s_c = ONE_Q;
    end
    y_c = mode2 ? ((s_c << 1) - ONE_Q) : s_c;
  end

  // Whole pipe advances together; any downstream stall freezes every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      k1        <= '0;
      f1        <= '0;
      mode1     <= 1'b0;
      tag1      <= '0;
      lo1       <= 1'b0;
      hi1       <= 1'b0;
      v2        <= 1'b0;
      a2        <= '0;
      d2        <= '0;
      f2        <= '0;
      mode2     <= 1'b0;
      tag2      <= '0;
      lo2       <= 1'b0;
      hi2       <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      k1        <= u_c[UW-1:FW];
      f1        <= u_c[FW-1:0];
      mode1     <= in_mode;
      tag1      <= in_tag;
      lo1       <= sat_lo_c;
      hi1       <= sat_hi_c;
      v2        <= v1;
      a2        <= tbl[k1];
      d2        <= tbl[k1 + KW'(1)] - tbl[k1];
      f2        <= f1;
      mode2     <= mode1;
      tag2      <= tag1;
      lo2       <= lo1;
      hi2       <= hi1;
      out_valid <= v2;
      out_y     <= y_c;
      out_tag   <= tag2;
    end
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Scoreboard bench for sigmoid_pipe: directed spec points, randomized traffic
// under backpressure against a real-arithmetic reference, and mid-stream reset.
module tb_sigmoid_pipe;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned TAG_W  = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] in_x      = '0;
  logic        in_mode   = 1'b0;
  logic [3:0]  in_tag    = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_y;
  logic [3:0]  out_tag;

  sigmoid_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   bp_en = 1'b0;

  logic [15:0] dir_x [12] = '{16'h0800, 16'hF800, 16'h0400, 16'h7000, 16'h7FFF, 16'h9000,
                              16'h8000, 16'h4000, 16'hC000, 16'h0000, 16'h0400, 16'h0000};
  bit          dir_m [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] dir_y [12] = '{16'h09F6, 16'h060A, 16'h08FB, 16'h1000, 16'h1000, 16'h0000,
                              16'h0000, 16'h1000, 16'hF000, 16'h0000, 16'h03EC, 16'h0800};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference: breakpoints straight from the logistic function, then the interpolation rule.
  function automatic int ref_table(input int k);
    real t;
    real v;
    if (k == 0) return 0;
    if (k == 28) return 4096;
    t = -7.0 + 0.5 * k;
    v = 4096.0 / (1.0 + $exp(-t));
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic logic [15:0] ref_y(input logic [15:0] x, input logic m);
    int xi;
    int z;
    int s;
    int u;
    int k;
    int f;
    int a;
    int b;
    xi = $signed(x);
    z  = m ? 2 * xi : xi;
    if (z <= -7 * 4096) begin
      s = 0;
    end else if (z >= 7 * 4096) begin
      s = 4096;
    end else begin
      u = z + 7 * 4096;
      k = u / 2048;
      f = u % 2048;
      a = ref_table(k);
      b = ref_table(k + 1);
      s = a + ((b - a) * f) / 2048;
    end
    return m ? 16'(2 * s - 4096) : 16'(s);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  exp_t        mon_e;
  bit          stall_prev = 1'b0;
  logic [15:0] y_prev;
  logic [3:0]  tag_prev;

  // Monitor: handshake rule, hold-while-stalled, and in-order scoreboard pops.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_y", 32'(out_y), 32'(y_prev));
        check("hold_tag", 32'(out_tag), 32'(tag_prev));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: y=0x%0h tag=0x%0h with nothing outstanding", out_y, out_tag);
        end else begin
          mon_e = sb.pop_front();
          check("out_y", 32'(out_y), 32'(mon_e.y));
          check("out_tag", 32'(out_tag), 32'(mon_e.tag));
          if (mon_e.lat) check("latency", 32'(cycle - mon_e.acc), 32'd3);
        end
      end
      stall_prev = out_valid && !out_ready;
      y_prev     = out_y;
      tag_prev   = out_tag;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [15:0] x, input logic m, input logic [3:0] t,
                      input logic [15:0] y_exp, input bit lat);
    bit   done;
    exp_t e;
    done     = 1'b0;
    in_valid = 1'b1;
    in_x     = x;
    in_mode  = m;
    in_tag   = t;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        e.y   = y_exp;
        e.tag = t;
        e.acc = cycle;
        e.lat = lat;
        sb.push_back(e);
        done  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: tag 0x%0h never accepted", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results never emerged", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] x;
    logic        m;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_y", 32'(out_y), 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(16'h0000, 1'b0, 4'h1, 16'h0800, 1'b1);
    drain();

    for (int i = 0; i < 12; i++) send(dir_x[i], dir_m[i], 4'(i), dir_y[i], 1'b0);
    drain();

    bp_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      x = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 32767) - 16384);
      m = 1'($urandom_range(0, 1));
      send(x, m, 4'(i), ref_y(x, m), 1'b0);
    end
    drain();
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(16'h1234, 1'b0, 4'h5, ref_y(16'h1234, 1'b0), 1'b0);
    send(16'hE000, 1'b1, 4'h6, ref_y(16'hE000, 1'b1), 1'b0);
    send(16'h0200, 1'b1, 4'h7, ref_y(16'h0200, 1'b1), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_y", 32'(out_y), 32'd0);
    check("midrst_out_tag", 32'(out_tag), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    send(16'h0800, 1'b0, 4'hA, 16'h09F6, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
